// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 SEQ datapath: register ID and word
// types, the special register IDs, instruction codes used by the
// neighbouring stages, and a small helper for "is this a real register".
// No ports (package).
// ---------------------------------------------------------------------------
package y86_pkg;

  typedef logic [3:0]  regid_t;
  typedef logic [63:0] word_t;

  localparam regid_t RNONE    = 4'hF;
  localparam regid_t RRSP     = 4'h4;
  localparam int     NUM_REGS = 15;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  // RNONE is the only ID without backing storage.
  function automatic logic isReg(input regid_t id);
    return id != RNONE;
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// ---------------------------------------------------------------------------
// reg_read_port
// One combinational read port of the register file, including the
// write-through bypass mux.
// Ports:
//   src_i   - register ID to read
//   wbEn_i  - commit enable; bypass only applies while writes will commit
//   dstE_i  - E-port write ID,  valE_i - E-port write data
//   dstM_i  - M-port write ID,  valM_i - M-port write data
//   regs_i  - stored register array (IDs 0..14)
//   val_o   - read data
// ---------------------------------------------------------------------------
module reg_read_port
  import y86_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  regid_t                src_i,
  input  logic                  wbEn_i,
  input  regid_t                dstE_i,
  input  word_t                 valE_i,
  input  regid_t                dstM_i,
  input  word_t                 valM_i,
  input  word_t [NUM_REGS-1:0]  regs_i,
  output word_t                 val_o
);

  // M is checked before E so a read matches what storage will hold after
  // the edge when both ports target the same register (popq %rsp).
  always_comb begin
    val_o = '0;
    if (isReg(src_i)) begin
      if (BYPASS && wbEn_i && isReg(dstM_i) && (src_i == dstM_i)) begin
        val_o = valM_i;
      end else if (BYPASS && wbEn_i && isReg(dstE_i) && (src_i == dstE_i)) begin
        val_o = valE_i;
      end else begin
        val_o = regs_i[src_i];
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// Y86-64 architectural register file (15 x 64-bit) for the SEQ processor.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   srcA, srcB      - read IDs;  valA, valB - read data (0-cycle latency)
//   dstE, valE      - E-port write ID/data (RNONE = no write)
//   dstM, valM      - M-port write ID/data (RNONE = no write; wins on clash)
//   wb_en           - global commit enable
//   rsp_q           - stored %rsp, never bypassed
//   wr_cnt          - saturating count of committed register writes
// Parameters: SP_INIT (reset value of %rsp), BYPASS (write-through reads).
// ---------------------------------------------------------------------------
module reg_file
  import y86_pkg::*;
#(
  parameter word_t SP_INIT = 64'h0,
  parameter bit    BYPASS  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  regid_t       srcA,
  input  regid_t       srcB,
  output word_t        valA,
  output word_t        valB,
  input  regid_t       dstE,
  input  word_t        valE,
  input  regid_t       dstM,
  input  word_t        valM,
  input  logic         wb_en,
  output word_t        rsp_q,
  output logic [31:0]  wr_cnt
);

  word_t [NUM_REGS-1:0] regs_q;
  logic  [31:0]         wrCnt_q;
  logic  [31:0]         wrCnt_d;
  logic  [1:0]          wrInc;
  logic  [32:0]         cntSum;

  // Number of distinct registers committed this edge; an E/M collision
  // touches only one register so it counts once. The 33-bit sum exposes
  // the carry used to saturate the counter.
  always_comb begin
    wrInc = 2'd0;
    if (wb_en) begin
      if (isReg(dstE)) begin
        wrInc = wrInc + 2'd1;
      end
      if (isReg(dstM) && (dstM != dstE)) begin
        wrInc = wrInc + 2'd1;
      end
    end
    cntSum  = {1'b0, wrCnt_q} + {31'd0, wrInc};
    wrCnt_d = cntSum[32] ? 32'hFFFF_FFFF : cntSum[31:0];
  end

  // Reset beats any write. The M write is issued after the E write so on a
  // collision the later nonblocking assignment (M) is the one that sticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q       <= '0;
      regs_q[RRSP] <= SP_INIT;
      wrCnt_q      <= '0;
    end else if (wb_en) begin
      if (isReg(dstE)) begin
        regs_q[dstE] <= valE;
      end
      if (isReg(dstM)) begin
        regs_q[dstM] <= valM;
      end
      wrCnt_q <= wrCnt_d;
    end
  end

  reg_read_port #(.BYPASS(BYPASS)) portA (
    .src_i  (srcA),
    .wbEn_i (wb_en),
    .dstE_i (dstE),
    .valE_i (valE),
    .dstM_i (dstM),
    .valM_i (valM),
    .regs_i (regs_q),
    .val_o  (valA)
  );

  reg_read_port #(.BYPASS(BYPASS)) portB (
    .src_i  (srcB),
    .wbEn_i (wb_en),
    .dstE_i (dstE),
    .valE_i (valE),
    .dstM_i (dstM),
    .valM_i (valM),
    .regs_i (regs_q),
    .val_o  (valB)
  );

  assign rsp_q  = regs_q[RRSP];
  assign wr_cnt = wrCnt_q;

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
// Self-checking bench for reg_file. Two instances share every input: one
// with write-through bypass, one without, both with %rsp reset to 0x100.
// ---------------------------------------------------------------------------
module tb_reg_file;

  typedef struct {
    logic        wbEn;
    logic [3:0]  dstE;
    logic [63:0] valE;
    logic [3:0]  dstM;
    logic [63:0] valM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] expA;
    logic [63:0] expB;
    logic [63:0] expRsp;
    logic [31:0] expCnt;
    logic [63:0] expANb;
  } vec_t;

  localparam int NVEC = 15;

  logic        clk;
  logic        rstN;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valE, valM;
  logic        wbEn;
  logic [63:0] valA, valB, rspQ;
  logic [31:0] wrCnt;
  logic [63:0] valANb, valBNb, rspQNb;
  logic [31:0] wrCntNb;

  int total = 0;
  int bad   = 0;
  vec_t vecs[NVEC];

  reg_file #(.SP_INIT(64'h100), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rstN),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .wb_en(wbEn), .rsp_q(rspQ), .wr_cnt(wrCnt)
  );

  reg_file #(.SP_INIT(64'h100), .BYPASS(1'b0)) dutNb (
    .clk(clk), .rst_n(rstN),
    .srcA(srcA), .srcB(srcB), .valA(valANb), .valB(valBNb),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .wb_en(wbEn), .rsp_q(rspQNb), .wr_cnt(wrCntNb)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(
    input logic wb, input logic [3:0] de, input logic [63:0] ve,
    input logic [3:0] dm, input logic [63:0] vm,
    input logic [3:0] sa, input logic [3:0] sb,
    input logic [63:0] ea, input logic [63:0] eb,
    input logic [63:0] er, input logic [31:0] ec, input logic [63:0] enb);
    vec_t v;
    v.wbEn = wb;  v.dstE = de; v.valE = ve; v.dstM = dm; v.valM = vm;
    v.srcA = sa;  v.srcB = sb; v.expA = ea; v.expB = eb;
    v.expRsp = er; v.expCnt = ec; v.expANb = enb;
    return v;
  endfunction

  // Drive all DUT inputs together from one place.
  task automatic applyStimulus(
    input logic rst, input logic wb,
    input logic [3:0] de, input logic [63:0] ve,
    input logic [3:0] dm, input logic [63:0] vm,
    input logic [3:0] sa, input logic [3:0] sb);
    rstN = rst; wbEn = wb;
    dstE = de;  valE = ve; dstM = dm; valM = vm;
    srcA = sa;  srcB = sb;
  endtask

  // One comparison: counts it and reports a line when it disagrees.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Stimulus changes on the falling edge and outputs are sampled 1 ns later,
  // so each vector sees the state committed by the previous vector's edge.
  initial begin
    vecs[0]  = mkVec(0, 4'hF, 64'h0,    4'hF, 64'h0,  4'h4, 4'h0, 64'h100,  64'h0,  64'h100, 32'd0, 64'h100);
    vecs[1]  = mkVec(1, 4'h2, 64'hAA,   4'h3, 64'hBB, 4'h2, 4'h3, 64'hAA,   64'hBB, 64'h100, 32'd0, 64'h0);
    vecs[2]  = mkVec(0, 4'hF, 64'h0,    4'hF, 64'h0,  4'h2, 4'h3, 64'hAA,   64'hBB, 64'h100, 32'd2, 64'hAA);
    vecs[3]  = mkVec(1, 4'h4, 64'h108,  4'h4, 64'h55, 4'h4, 4'h4, 64'h55,   64'h55, 64'h100, 32'd2, 64'h100);
    vecs[4]  = mkVec(0, 4'hF, 64'h0,    4'hF, 64'h0,  4'h4, 4'h2, 64'h55,   64'hAA, 64'h55,  32'd3, 64'h55);
    vecs[5]  = mkVec(1, 4'h7, 64'h1234, 4'hF, 64'h0,  4'h7, 4'h7, 64'h1234, 64'h1234, 64'h55, 32'd3, 64'h0);
    vecs[6]  = mkVec(0, 4'h1, 64'hFF,   4'hF, 64'h0,  4'h7, 4'h1, 64'h1234, 64'h0,  64'h55,  32'd4, 64'h1234);
    vecs[7]  = mkVec(0, 4'hF, 64'h0,    4'hF, 64'h0,  4'h1, 4'hF, 64'h0,    64'h0,  64'h55,  32'd4, 64'h0);
    vecs[8]  = mkVec(1, 4'hF, 64'h9,    4'hF, 64'h0,  4'hF, 4'h7, 64'h0,    64'h1234, 64'h55, 32'd4, 64'h0);
    vecs[9]  = mkVec(0, 4'hF, 64'h0,    4'hF, 64'h0,  4'hF, 4'h2, 64'h0,    64'hAA, 64'h55,  32'd4, 64'h0);
    vecs[10] = mkVec(1, 4'h5, 64'h11,   4'h6, 64'h22, 4'h5, 4'h6, 64'h11,   64'h22, 64'h55,  32'd4, 64'h0);
    vecs[11] = mkVec(1, 4'h6, 64'h33,   4'h5, 64'h44, 4'h6, 4'h5, 64'h33,   64'h44, 64'h55,  32'd6, 64'h22);
    vecs[12] = mkVec(0, 4'hF, 64'h0,    4'hF, 64'h0,  4'h5, 4'h6, 64'h44,   64'h33, 64'h55,  32'd8, 64'h44);
    vecs[13] = mkVec(1, 4'hE, 64'hDEAD, 4'h0, 64'h1,  4'hE, 4'h0, 64'hDEAD, 64'h1,  64'h55,  32'd8, 64'h0);
    vecs[14] = mkVec(0, 4'hF, 64'h0,    4'hF, 64'h0,  4'hE, 4'h0, 64'hDEAD, 64'h1,  64'h55,  32'd10, 64'hDEAD);

    applyStimulus(1'b0, 1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h4, 4'h0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, vecs[i].wbEn, vecs[i].dstE, vecs[i].valE,
                    vecs[i].dstM, vecs[i].valM, vecs[i].srcA, vecs[i].srcB);
      #1;
      checkOutput($sformatf("v%0d valA", i),    valA,          vecs[i].expA);
      checkOutput($sformatf("v%0d valB", i),    valB,          vecs[i].expB);
      checkOutput($sformatf("v%0d rsp_q", i),   rspQ,          vecs[i].expRsp);
      checkOutput($sformatf("v%0d wr_cnt", i),  {32'd0, wrCnt}, {32'd0, vecs[i].expCnt});
      checkOutput($sformatf("v%0d nb valA", i), valANb,        vecs[i].expANb);
    end

    // Reset asserted together with a write: the write must be dropped and
    // every register returns to its reset value.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 4'h2, 64'h66, 4'h5, 64'h77, 4'h5, 4'h4);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h5, 4'h4);
    #1;
    checkOutput("rstwr reg5",     valA,           64'h0);
    checkOutput("rstwr rsp read", valB,           64'h100);
    checkOutput("rstwr rsp_q",    rspQ,           64'h100);
    checkOutput("rstwr wr_cnt",   {32'd0, wrCnt}, 64'h0);
    checkOutput("rstwr nb reg5",  valANb,         64'h0);
    srcA = 4'h2; srcB = 4'hE;
    #1;
    checkOutput("rstwr reg2",     valA,           64'h0);
    checkOutput("rstwr reg14",    valB,           64'h0);

    // M write on its own counts once and lands one edge later.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 4'hF, 64'h0, 4'h4, 64'h200, 4'h4, 4'h4);
    #1;
    checkOutput("popm bypass",    valA,           64'h200);
    checkOutput("popm rsp old",   rspQ,           64'h100);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h4, 4'h4);
    #1;
    checkOutput("popm rsp new",   rspQ,           64'h200);
    checkOutput("popm nb valB",   valBNb,         64'h200);
    checkOutput("popm wr_cnt",    {32'd0, wrCnt}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
